// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the TX path and the baud generator.
package uart_pkg;

    localparam int BAUD_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    // A zero prescale selects the build-time default bit period.
    function automatic logic [BAUD_CNT_W-1:0] eff_period(
        input logic [BAUD_CNT_W-1:0] prescale,
        input logic [BAUD_CNT_W-1:0] dflt
    );
        return (prescale == '0) ? dflt : prescale;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter; tick marks the last clock of every bit.
// The period is captured on load so later changes only apply at the next load.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [BAUD_CNT_W-1:0] period,
    output logic                  tick
);

    logic [BAUD_CNT_W-1:0] cnt;
    logic [BAUD_CNT_W-1:0] period_q;

    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            period_q <= '0;
        end else if (load) begin
            cnt      <= period - BAUD_CNT_W'(1);
            period_q <= period;
        end else if (en) begin
            cnt <= tick ? (period_q - BAUD_CNT_W'(1)) : (cnt - BAUD_CNT_W'(1));
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input with a one-entry holding register,
// LSB-first 8N1/8N2 framing on a registered txd line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH       = 8,
    parameter int                    STOP_BITS        = 1,
    parameter logic [BAUD_CNT_W-1:0] DEFAULT_PRESCALE = 16'd868
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  txd,
    input  logic [BAUD_CNT_W-1:0] prescale
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_tx_state_t        state;
    uart_tx_state_t        state_nxt;
    logic                  hold_vld;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [DATA_WIDTH-1:0] shift;
    logic [IDX_W-1:0]      bit_idx;
    logic                  stop_idx;
    logic                  tick;
    logic                  deq;
    logic                  accept;
    logic                  last_data;
    logic                  last_stop;

    assign tx_ready  = !hold_vld;
    assign tx_busy   = (state != IDLE) || hold_vld;
    assign accept    = tx_valid && !hold_vld;
    assign last_data = (bit_idx == IDX_W'(DATA_WIDTH - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

    uart_baud_tick u_baud (
        .clk    (clk),
        .rst    (rst),
        .en     (state != IDLE),
        .load   (deq),
        .period (eff_period(prescale, DEFAULT_PRESCALE)),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dequeue from holding happens both from IDLE and straight out of the last
    // stop cycle, which is what makes back-to-back frames gapless.
    always_comb begin
        state_nxt = state;
        deq       = 1'b0;
        case (state)
            IDLE: begin
                if (hold_vld) begin
                    state_nxt = START;
                    deq       = 1'b1;
                end
            end
            START: begin
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                if (tick && last_data) state_nxt = STOP;
            end
            STOP: begin
                if (tick && last_stop) begin
                    if (hold_vld) begin
                        state_nxt = START;
                        deq       = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld <= 1'b0;
        end else if (accept) begin
            hold_vld <= 1'b1;
        end else if (deq) begin
            hold_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) hold_data <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (deq) begin
            shift <= hold_data;
        end else if (state == DATA && tick) begin
            shift <= shift >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else if (deq) begin
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else if (tick) begin
            if (state == DATA) bit_idx <= last_data ? '0 : bit_idx + 1'b1;
            if (state == STOP) stop_idx <= last_stop ? 1'b0 : 1'b1;
        end
    end

    // txd trails the state by one clock, so every level still lasts one full period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txd <= 1'b1;
        end else begin
            case (state)
                START:   txd <= 1'b0;
                DATA:    txd <= shift[0];
                default: txd <= 1'b1;
            endcase
        end
    end

endmodule
